// File: rtl/sprite_line_engine_if.sv
// Config write bus for the sprite line engine: one 32-bit slot register per write.
interface sprite_line_engine_if;
    logic        cfg_wr;
    logic [3:0]  cfg_addr;
    logic [3:0]  cfg_wstrb;
    logic [31:0] cfg_wdata;

    modport master (output cfg_wr, cfg_addr, cfg_wstrb, cfg_wdata);
    modport slave  (input  cfg_wr, cfg_addr, cfg_wstrb, cfg_wdata);
endinterface

// File: rtl/sprite_line_engine.sv
// Scanline sprite engine: fetches one pattern row per slot during hblank, then
// serialises the slot line buffers against pix_x with priority and collision.
module sprite_slot #(
    parameter int SPRITE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [SPRITE_W*2-1:0] row,
    input  logic [8:0]            x,
    input  logic                  flip_x,
    input  logic [3:0]            palette,
    input  logic [8:0]            pix_x,
    output logic [1:0]            pixel,
    output logic [3:0]            pal
);
    localparam int DW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

    logic [SPRITE_W*2-1:0] row_buf;
    logic [8:0]            x_q;
    logic                  flip_q;
    logic [3:0]            pal_q;
    logic [9:0]            d;
    logic [DW-1:0]         pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_buf <= '0;
            x_q     <= '0;
            flip_q  <= 1'b0;
            pal_q   <= '0;
        end else if (load) begin
            row_buf <= row;
            x_q     <= x;
            flip_q  <= flip_x;
            pal_q   <= palette;
        end
    end

    // Pixel 0 sits in the top two bits; flip-x reads the row from the other end.
    always_comb begin
        d     = {1'b0, pix_x} - {1'b0, x_q};
        pos   = flip_q ? d[DW-1:0] : DW'(SPRITE_W - 1) - d[DW-1:0];
        pixel = 2'b00;
        if (d < 10'(SPRITE_W))
            pixel = row_buf[{pos, 1'b0} +: 2];
    end

    assign pal = pal_q;
endmodule

module sprite_line_engine #(
    parameter int NUM_SPRITES = 8,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int PAT_W       = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    sprite_line_engine_if.slave                 cfg,
    input  logic                                line_start,
    input  logic [8:0]                          line_y,
    output logic [PAT_W+$clog2(SPRITE_H)-1:0]   mem_raddr,
    input  logic [SPRITE_W*2-1:0]               mem_rdata,
    input  logic                                pix_valid,
    input  logic [8:0]                          pix_x,
    output logic                                out_visible,
    output logic [1:0]                          out_pixel,
    output logic [3:0]                          out_palette,
    output logic                                fetch_done,
    output logic [NUM_SPRITES-1:0]              coll_mask,
    input  logic                                coll_clr
);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int AW     = PAT_W + ROW_W;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, LOAD} state_t;

    state_t                          state_q, state_d;
    logic [SLOT_W-1:0]               slot_q, slot_d;
    logic                            fetch_done_d;
    logic                            load;
    logic [8:0]                      line_y_q;
    logic [AW-1:0]                   raddr_q, raddr_calc;
    logic                            hit_q, hit_calc;
    logic [31:0]                     cfg_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]          cfg_unused;
    logic [31:0]                     cur;
    logic [9:0]                      cur_y, ly;
    logic [ROW_W-1:0]                row;
    logic [NUM_SPRITES-1:0][1:0]     slot_pix;
    logic [NUM_SPRITES-1:0][3:0]     slot_pal;
    logic [NUM_SPRITES-1:0]          nz;
    logic                            win_vis, multi;
    logic [1:0]                      win_pix;
    logic [3:0]                      win_pal;
    logic [SPRITE_W*2-1:0]           row_in;

    // Config registers and per-slot line logic.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset)
                cfg_q[g] <= '0;
            else if (cfg.cfg_wr && cfg.cfg_addr == 4'(g))
                for (int b = 0; b < 4; b++)
                    if (cfg.cfg_wstrb[b])
                        cfg_q[g][b*8 +: 8] <= cfg.cfg_wdata[b*8 +: 8];
        end
        assign cfg_unused[g] = ^cfg_q[g];

        sprite_slot #(.SPRITE_W(SPRITE_W)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load    (load && slot_q == SLOT_W'(g)),
            .row     (row_in),
            .x       (cfg_q[g][17:9]),
            .flip_x  (cfg_q[g][30]),
            .palette (cfg_q[g][27:24]),
            .pix_x   (pix_x),
            .pixel   (slot_pix[g]),
            .pal     (slot_pal[g])
        );
    end

    assign row_in = hit_q ? mem_rdata : '0;

    // Row address and y-hit for the slot being fetched; 10-bit compare avoids wrap.
    always_comb begin
        cur        = cfg_q[slot_q];
        cur_y      = {1'b0, cur[8:0]};
        ly         = {1'b0, line_y_q};
        hit_calc   = cur[28] && (ly >= cur_y) && (ly < cur_y + 10'(SPRITE_H));
        row        = line_y_q[ROW_W-1:0] - cur[ROW_W-1:0];
        if (cur[29])
            row = ~row;
        raddr_calc = {cur[PAT_W+17:18], row};
    end

    assign mem_raddr = (state_q == ADDR) ? raddr_calc : raddr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            fetch_done <= 1'b0;
            line_y_q   <= '0;
            raddr_q    <= '0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            fetch_done <= fetch_done_d;
            if (line_start)
                line_y_q <= line_y;
            if (state_q == ADDR) begin
                raddr_q <= raddr_calc;
                hit_q   <= hit_calc;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        fetch_done_d = fetch_done;
        load         = 1'b0;
        case (state_q)
            ADDR: state_d = WAIT;
            WAIT: state_d = LOAD;
            LOAD: begin
                load = 1'b1;
                if (slot_q == SLOT_W'(NUM_SPRITES - 1)) begin
                    state_d      = IDLE;
                    fetch_done_d = 1'b1;
                end else begin
                    state_d = ADDR;
                    slot_d  = slot_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (line_start) begin
            state_d      = ADDR;
            slot_d       = '0;
            fetch_done_d = 1'b0;
        end
    end

    // Descending scan so the lowest-numbered opaque slot is the last to assign.
    always_comb begin
        nz      = '0;
        win_vis = 1'b0;
        win_pix = '0;
        win_pal = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            nz[i] = |slot_pix[i];
            if (nz[i]) begin
                win_vis = 1'b1;
                win_pix = slot_pix[i];
                win_pal = slot_pal[i];
            end
        end
        multi = (nz & (nz - 1'b1)) != '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_visible <= 1'b0;
            out_pixel   <= '0;
            out_palette <= '0;
            coll_mask   <= '0;
        end else begin
            if (pix_valid) begin
                out_visible <= win_vis;
                out_pixel   <= win_pix;
                out_palette <= win_pal;
            end
            coll_mask <= (coll_clr ? '0 : coll_mask) | ((pix_valid && multi) ? nz : '0);
        end
    end
endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: pattern memory model, table vectors and a
// scoreboard of expected pixel outputs.
module tb_sprite_line_engine;
    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          reset, line_start, pix_valid, coll_clr;
    logic [8:0]    line_y, pix_x, mem_raddr;
    logic [31:0]   mem_rdata, rd_d1;
    logic          out_visible, fetch_done;
    logic [1:0]    out_pixel;
    logic [3:0]    out_palette;
    logic [NS-1:0] coll_mask;
    logic [31:0]   pat_mem [512];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          vis;
        logic [1:0]    pix;
        logic [3:0]    pal;
        logic [NS-1:0] coll;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [8:0] x;
        logic       vis;
        logic [1:0] pix;
        logic [3:0] pal;
    } vec_t;
    vec_t vt[7];

    sprite_line_engine_if cfg_bus();

    sprite_line_engine #(.NUM_SPRITES(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_bus),
        .line_start  (line_start),
        .line_y      (line_y),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .out_visible (out_visible),
        .out_pixel   (out_pixel),
        .out_palette (out_palette),
        .fetch_done  (fetch_done),
        .coll_mask   (coll_mask),
        .coll_clr    (coll_clr)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency pattern memory.
    always @(posedge clk) begin
        rd_d1     <= pat_mem[mem_raddr];
        mem_rdata <= rd_d1;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int y, input int x, input int pat, input int pal,
                                       input bit en, input bit fy, input bit fx);
        logic [31:0] w;
        w        = '0;
        w[8:0]   = 9'(y);
        w[17:9]  = 9'(x);
        w[22:18] = 5'(pat);
        w[27:24] = 4'(pal);
        w[28]    = en;
        w[29]    = fy;
        w[30]    = fx;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] slot, input logic [3:0] strb, input logic [31:0] data);
        cfg_bus.cfg_wr    = 1'b1;
        cfg_bus.cfg_addr  = slot;
        cfg_bus.cfg_wstrb = strb;
        cfg_bus.cfg_wdata = data;
        tick();
        cfg_bus.cfg_wr    = 1'b0;
    endtask

    // Pulses line_start and waits (bounded) for fetch_done.
    task automatic run_line(input logic [8:0] y, output int cyc, output logic [8:0] raddr0,
                            output logic fd0);
        line_start = 1'b1;
        line_y     = y;
        tick();
        line_start = 1'b0;
        raddr0     = mem_raddr;
        fd0        = fetch_done;
        cyc        = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (fetch_done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic pix(input logic [8:0] x, input logic clr, input logic vis, input logic [1:0] p,
                       input logic [3:0] pal, input logic [NS-1:0] coll, input string nm);
        exp_t e;
        pix_x     = x;
        pix_valid = 1'b1;
        coll_clr  = clr;
        sb.push_back('{vis, p, pal, coll});
        tick();
        pix_valid = 1'b0;
        coll_clr  = 1'b0;
        e = sb.pop_front();
        check({nm, ".vis"},  out_visible, e.vis);
        check({nm, ".pix"},  out_pixel,   e.pix);
        check({nm, ".pal"},  out_palette, e.pal);
        check({nm, ".coll"}, coll_mask,   e.coll);
    endtask

    initial begin
        int         cyc;
        logic [8:0] ra;
        logic       fd;

        for (int i = 0; i < 512; i++) pat_mem[i] = '0;
        pat_mem[50]  = 32'hC000_0006;   // pattern 3 row 2
        pat_mem[66]  = 32'h0000_0001;   // pattern 4 row 2
        pat_mem[111] = 32'h4000_0000;   // pattern 6 row 15
        pat_mem[19]  = 32'hC000_0000;   // pattern 1 row 3
        pat_mem[35]  = 32'h8000_0000;   // pattern 2 row 3
        pat_mem[91]  = 32'hFFFF_FFFF;   // pattern 5 row 11
        pat_mem[92]  = 32'hFFFF_FFFF;   // pattern 5 row 12

        vt[0] = '{9'd20, 1'b1, 2'd3, 4'd5};
        vt[1] = '{9'd34, 1'b1, 2'd1, 4'd5};
        vt[2] = '{9'd35, 1'b1, 2'd2, 4'd5};
        vt[3] = '{9'd36, 1'b0, 2'd0, 4'd0};
        vt[4] = '{9'd19, 1'b0, 2'd0, 4'd0};
        vt[5] = '{9'd21, 1'b0, 2'd0, 4'd0};
        vt[6] = '{9'd27, 1'b0, 2'd0, 4'd0};

        reset = 1'b1; line_start = 1'b0; line_y = '0; pix_valid = 1'b0; pix_x = '0;
        coll_clr = 1'b0;
        cfg_bus.cfg_wr = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_wstrb = '0; cfg_bus.cfg_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.visible",    out_visible, 0);
        check("rst.pixel",      out_pixel,   0);
        check("rst.palette",    out_palette, 0);
        check("rst.fetch_done", fetch_done,  0);
        check("rst.coll_mask",  coll_mask,   0);
        check("rst.mem_raddr",  mem_raddr,   0);

        // Basic fetch and MSB-first pixel order.
        cfg_write(4'd0, 4'hF, mk(10, 20, 3, 5, 1, 0, 0));
        run_line(9'd12, cyc, ra, fd);
        check("basic.raddr", ra, 9'd50);
        check("basic.fetch_cycles", cyc, 24);
        foreach (vt[i])
            pix(vt[i].x, 1'b0, vt[i].vis, vt[i].pix, vt[i].pal, '0, $sformatf("vec%0d", i));

        // Flip-x.
        cfg_write(4'd0, 4'hF, mk(10, 20, 4, 5, 1, 0, 1));
        run_line(9'd12, cyc, ra, fd);
        check("flipx.raddr", ra, 9'd66);
        check("flipx.fd_cleared", fd, 0);
        check("flipx.fetch_cycles", cyc, 24);
        pix(9'd20, 1'b0, 1'b1, 2'd1, 4'd5, '0, "flipx.x20");
        pix(9'd35, 1'b0, 1'b0, 2'd0, 4'd0, '0, "flipx.x35");

        // Flip-y, then a config write after LOAD must not disturb the line.
        cfg_write(4'd0, 4'hF, mk(10, 20, 6, 5, 1, 1, 0));
        run_line(9'd10, cyc, ra, fd);
        check("flipy.raddr", ra, 9'd111);
        cfg_write(4'd0, 4'hF, mk(10, 100, 6, 5, 1, 1, 0));
        pix(9'd20, 1'b0, 1'b1, 2'd1, 4'd5, '0, "flipy.x20_after_cfg");

        // Priority and collisions between slots 1 and 2.
        cfg_write(4'd0, 4'hF, 32'h0);
        cfg_write(4'd1, 4'hF, mk(0, 5, 1, 7, 1, 0, 0));
        cfg_write(4'd2, 4'hF, mk(0, 5, 2, 9, 1, 0, 0));
        run_line(9'd3, cyc, ra, fd);
        pix(9'd5,   1'b0, 1'b1, 2'd3, 4'd7, 8'b0000_0110, "coll.hit");
        pix(9'd6,   1'b1, 1'b0, 2'd0, 4'd0, 8'b0000_0000, "coll.clr");
        pix(9'd5,   1'b1, 1'b1, 2'd3, 4'd7, 8'b0000_0110, "coll.clr_vs_hit");
        pix(9'd200, 1'b1, 1'b0, 2'd0, 4'd0, 8'b0000_0000, "coll.clr2");

        // Byte-lane write moves slot 2 off the line; slot 8 does not exist.
        cfg_write(4'd2, 4'b0001, 32'h0000_00FF);
        cfg_write(4'd8, 4'hF, mk(0, 5, 1, 3, 1, 0, 0));
        run_line(9'd3, cyc, ra, fd);
        pix(9'd5, 1'b0, 1'b1, 2'd3, 4'd7, '0, "wstrb.slot1_only");

        // No wrap at the bottom of the 9-bit line space.
        cfg_write(4'd1, 4'hF, mk(250, 20, 5, 4, 1, 0, 0));
        run_line(9'd5, cyc, ra, fd);
        pix(9'd20, 1'b0, 1'b0, 2'd0, 4'd0, '0, "nowrap.y250");
        cfg_write(4'd1, 4'hF, mk(505, 20, 5, 4, 1, 0, 0));
        run_line(9'd5, cyc, ra, fd);
        pix(9'd20, 1'b0, 1'b0, 2'd0, 4'd0, '0, "nowrap.y505");

        // Pixels during a fetch see buffers as they fill; restart at slot 3.
        cfg_write(4'd0, 4'hF, mk(10, 20, 3, 5, 1, 0, 0));
        cfg_write(4'd1, 4'hF, mk(10, 20, 3, 6, 1, 0, 0));
        cfg_write(4'd2, 4'hF, 32'h0);
        line_start = 1'b1;
        line_y     = 9'd12;
        tick();
        line_start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 3)      pix(9'd20, 1'b0, 1'b0, 2'd0, 4'd0, 8'b00, $sformatf("midfetch%0d", i));
            else if (i <= 6) pix(9'd20, 1'b0, 1'b1, 2'd3, 4'd5, 8'b00, $sformatf("midfetch%0d", i));
            else             pix(9'd20, 1'b0, 1'b1, 2'd3, 4'd5, 8'b11, $sformatf("midfetch%0d", i));
        end
        check("restart.fd_mid", fetch_done, 0);
        run_line(9'd12, cyc, ra, fd);
        check("restart.raddr", ra, 9'd50);
        check("restart.fetch_cycles", cyc, 24);
        pix(9'd20, 1'b0, 1'b1, 2'd3, 4'd5, 8'b11, "restart.x20");

        // Reset during LOAD beats line_start, cfg_wr and pix_valid.
        line_start = 1'b1;
        line_y     = 9'd12;
        tick();
        line_start = 1'b0;
        tick();
        tick();
        reset = 1'b1; line_start = 1'b1; pix_valid = 1'b1; pix_x = 9'd20;
        cfg_bus.cfg_wr = 1'b1; cfg_bus.cfg_addr = 4'd3; cfg_bus.cfg_wstrb = 4'hF;
        cfg_bus.cfg_wdata = mk(10, 20, 3, 5, 1, 0, 0);
        tick();
        reset = 1'b0; line_start = 1'b0; pix_valid = 1'b0; cfg_bus.cfg_wr = 1'b0;
        check("rstload.fetch_done", fetch_done,  0);
        check("rstload.coll_mask",  coll_mask,   0);
        check("rstload.visible",    out_visible, 0);
        check("rstload.mem_raddr",  mem_raddr,   0);
        repeat (30) tick();
        check("rstload.idle", fetch_done, 0);
        run_line(9'd12, cyc, ra, fd);
        check("rstload.fetch_cycles", cyc, 24);
        pix(9'd20, 1'b0, 1'b0, 2'd0, 4'd0, '0, "rstload.cfg_ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
